// File: rtl/divider32b_sequencer.sv
// Valid/ready front/back end for the 32-bit unsigned restoring divider core: sign handling, bypasses, start/finish sequencing.
// Optional core watchdog in WAIT is enabled with `define DIV_SEQ_TIMEOUT_EN.
module divider32b_sequencer #(
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_quo,
    output logic [31:0] resp_rem,
    output logic        resp_dz,
    output logic        resp_err,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [32:0] div_quo,
    input  logic [31:0] div_rem,
    input  logic        div_finish
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_neg_q, r_neg_r, r_dz, r_err;
    logic [31:0] r_quo, r_rem, r_div_a, r_div_b;

    logic        w_accept, w_dz, w_ovf, w_timeout;
    logic [31:0] w_mag_a, w_mag_b, w_fix_q, w_fix_r;

    assign w_accept = req_valid & req_ready;
    assign w_mag_a  = (req_signed & req_a[31]) ? -req_a : req_a;
    assign w_mag_b  = (req_signed & req_b[31]) ? -req_b : req_b;
    assign w_dz     = (req_b == 32'd0);
    assign w_ovf    = req_signed & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);
    // Remainder sign follows the dividend; quotient sign is the XOR of operand signs.
    assign w_fix_q  = r_neg_q ? -div_quo[31:0] : div_quo[31:0];
    assign w_fix_r  = r_neg_r ? -div_rem : div_rem;

`ifdef DIV_SEQ_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_unused;
    assign w_unused  = &{1'b0, div_quo[32]};
    assign w_timeout = (r_state == S_WAIT) & ~div_finish & (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_cnt <= 8'd0;
        else if (r_state == S_ARM)  r_cnt <= 8'd0;
        else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
    end
`else
    logic w_unused;
    assign w_unused  = &{1'b0, div_quo[32], TIMEOUT_CYCLES[0]};
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_dz | w_ovf) ? S_DONE : S_START;
            S_START: w_next = S_ARM;
            // finish may still be high from the previous op, so ARM never looks at it
            S_ARM:   w_next = S_WAIT;
            S_WAIT:  if (div_finish | w_timeout) w_next = S_DONE;
            S_DONE:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE) & ~rst;
        resp_valid = (r_state == S_DONE);
        div_start  = (r_state == S_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_err   <= 1'b0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_div_a <= 32'd0;
            r_div_b <= 32'd0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_neg_q <= req_signed & (req_a[31] ^ req_b[31]);
            r_neg_r <= req_signed & req_a[31];
            r_dz    <= w_dz;
            r_err   <= 1'b0;
            if (w_dz) begin
                r_quo <= 32'hFFFF_FFFF;
                r_rem <= req_a;
            end else if (w_ovf) begin
                r_quo <= 32'h8000_0000;
                r_rem <= 32'd0;
            end else begin
                r_div_a <= w_mag_a;
                r_div_b <= w_mag_b;
            end
        end else if (r_state == S_WAIT) begin
            if (div_finish) begin
                r_quo <= w_fix_q;
                r_rem <= w_fix_r;
            end else if (w_timeout) begin
                r_err <= 1'b1;
                r_quo <= 32'd0;
                r_rem <= 32'd0;
            end
        end
    end

    assign resp_quo = r_quo;
    assign resp_rem = r_rem;
    assign resp_dz  = r_dz;
    assign resp_err = r_err;
    assign div_a    = r_div_a;
    assign div_b    = r_div_b;
endmodule

// File: tb/tb_divider32b_sequencer.sv
// Directed bench for divider32b_sequencer; the bench plays the divider core by hand.
module tb_divider32b_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_a = '0, req_b = '0, div_rem = '0;
    logic [32:0] div_quo = '0;
    logic        div_finish = 1'b0;
    logic        req_ready, resp_valid, resp_dz, resp_err, div_start;
    logic [31:0] resp_quo, resp_rem, div_a, div_b;

    int checks = 0, failures = 0;
    int n_start = 0, n_acc = 0, s0, a0;

    divider32b_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_quo(resp_quo),
        .resp_rem(resp_rem), .resp_dz(resp_dz), .resp_err(resp_err),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_quo(div_quo), .div_rem(div_rem), .div_finish(div_finish)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_start === 1'b1) n_start++;
        if (req_valid && req_ready === 1'b1) n_acc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    // Core-path request: the bench acts as the core and answers lag cycles into WAIT.
    task automatic core_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] da, input logic [31:0] db,
                           input logic [31:0] cq, input logic [31:0] cr, input int lag,
                           input logic [31:0] eq, input logic [31:0] er);
        int st;
        st = n_start;
        req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_start"}, {31'd0, div_start}, 32'd1);
        chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_div_a"}, div_a, da);
        chk({tag, "_div_b"}, div_b, db);
        tick();
        chk({tag, "_arm_nostart"}, {31'd0, div_start}, 32'd0);
        tick();
        chk({tag, "_wait_novalid"}, {31'd0, resp_valid}, 32'd0);
        if (lag > 0) begin
            div_finish = 1'b0;
            repeat (lag) begin
                tick();
                chk({tag, "_lag_novalid"}, {31'd0, resp_valid}, 32'd0);
            end
        end
        div_quo = {1'b1, cq}; div_rem = cr; div_finish = 1'b1;
        tick();
        chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_quo"}, resp_quo, eq);
        chk({tag, "_rem"}, resp_rem, er);
        chk({tag, "_dz"}, {31'd0, resp_dz}, 32'd0);
        chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
        chk({tag, "_one_start"}, n_start - st, 32'd1);
        // finish stays high (stale) with garbage data, as a real core would leave it
        div_quo = 33'h1_DEAD_BEEF; div_rem = 32'hCAFE_F00D;
    endtask

    task automatic bypass_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                             input logic [31:0] eq, input logic [31:0] er, input logic edz,
                             input logic [31:0] hold_a, input logic [31:0] hold_b);
        int st;
        st = n_start;
        req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_valid_c1"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_quo"}, resp_quo, eq);
        chk({tag, "_rem"}, resp_rem, er);
        chk({tag, "_dz"}, {31'd0, resp_dz}, {31'd0, edz});
        chk({tag, "_nostart"}, {31'd0, div_start}, 32'd0);
        chk({tag, "_div_a_hold"}, div_a, hold_a);
        chk({tag, "_div_b_hold"}, div_b, hold_b);
        tick();
        chk({tag, "_still_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_no_start_cnt"}, n_start - st, 32'd0);
        take_resp();
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_quo", resp_quo, 32'd0);
        chk("rst_rem", resp_rem, 32'd0);
        chk("rst_flags", {28'd0, resp_dz, resp_err, div_start, 1'b0}, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // 1. unsigned 100/7
        core_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 32'd14, 32'd2);
        take_resp();
        // 2. signed -7/2 and 7/-2, plus -8/-3 and an unsigned op with bit 31 set
        core_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        take_resp();
        core_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 0, 32'hFFFF_FFFD, 32'd1);
        take_resp();
        core_op("sm8_m3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd8, 32'd3, 32'd2, 32'd2, 1, 32'd2, 32'hFFFF_FFFE);
        take_resp();
        core_op("u_big", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0,
                32'h7FFF_FFFC, 32'd1);
        take_resp();

        // 3. divide by zero, both modes; div_a/div_b keep the previous core operands
        bypass_op("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 32'hFFFF_FFF9, 32'd2);
        bypass_op("sm5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFF9, 32'd2);
        // 4. signed overflow bypass; the same operands unsigned take the core path
        bypass_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        core_op("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                32'h8000_0000, 0, 32'd0, 32'h8000_0000);

        // 5. stale finish, held response with a waiting request: no accept until after DONE
        a0 = n_acc;
        req_a = 32'd50; req_b = 32'd5; req_signed = 1'b0; req_valid = 1'b1;
        repeat (5) begin
            tick();
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_quo", resp_quo, 32'd0);
            chk("hold_rem", resp_rem, 32'h8000_0000);
            chk("hold_no_ready", {31'd0, req_ready}, 32'd0);
        end
        chk("hold_no_accept", n_acc - a0, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("hold_idle", {31'd0, req_ready}, 32'd1);
        chk("hold_valid_drop", {31'd0, resp_valid}, 32'd0);
        core_op("u50_5", 32'd50, 32'd5, 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1, 32'd10, 32'd0);
        chk("single_accept", n_acc - a0, 32'd1);
        take_resp();

        // dz flag is cleared by the next accept
        bypass_op("u9_0", 32'd9, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd9, 1'b1, 32'd50, 32'd5);
        core_op("u9_4", 32'd9, 32'd4, 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 0, 32'd2, 32'd1);
        take_resp();

        // 6. reset in WAIT aborts; next request runs normally
        div_finish = 1'b0;
        s0 = n_start;
        req_a = 32'd77; req_b = 32'd3; req_signed = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("wait_pending", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_div_a", div_a, 32'd0);
        chk("arst_div_b", div_b, 32'd0);
        chk("arst_quo", resp_quo, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_no_restart", n_start - s0, 32'd1);
        chk("arst_idle", {31'd0, req_ready}, 32'd1);
        core_op("post_rst", 32'd77, 32'd3, 1'b0, 32'd77, 32'd3, 32'd25, 32'd2, 0, 32'd25, 32'd2);
        take_resp();

`ifdef DIV_SEQ_TIMEOUT_EN
        begin
            int n;
            n = 0;
            div_finish = 1'b0;
            req_a = 32'd10; req_b = 32'd3; req_signed = 1'b0; req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            repeat (2) tick();
            while (resp_valid !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            chk("to_cycles", n, 32'd80);
            chk("to_err", {31'd0, resp_err}, 32'd1);
            chk("to_quo", resp_quo, 32'd0);
            chk("to_rem", resp_rem, 32'd0);
            take_resp();
        end
`else
        chk("err_tied", {31'd0, resp_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
